// File: rtl/multicycle_ctrl.sv
// RV32I multi-cycle control FSM: FETCH/DECODE/EXEC/MEM/WB with TRAP on illegal opcode or memory timeout.
// Define MULTICYCLE_PERF_EN to add the instret/cycles performance counters.
module multicycle_ctrl #(
    parameter int MEM_TIMEOUT = 15,
    parameter int ALU_OP_W    = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [6:0]          opcode,
    input  logic [2:0]          fn3,
    input  logic                fn7_5,
    input  logic                br_taken,
    input  logic                mem_ready,
    output logic                mem_req,
    output logic                mem_we,
    output logic                ir_we,
    output logic                pc_we,
    output logic [1:0]          pc_src,
    output logic [1:0]          alu_src_a,
    output logic [1:0]          alu_src_b,
    output logic [ALU_OP_W-1:0] alu_op,
    output logic                rf_we,
    output logic [1:0]          wb_sel,
    output logic                illegal,
    output logic                bus_err,
    output logic [2:0]          state_o
`ifdef MULTICYCLE_PERF_EN
    ,
    output logic [31:0]         instret,
    output logic [31:0]         cycles
`endif
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_t;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LD    = 7'b0000011;
    localparam logic [6:0] OP_ST    = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    localparam logic [ALU_OP_W-1:0] ALU_ADD   = ALU_OP_W'(0);
    localparam logic [ALU_OP_W-1:0] ALU_SUB   = ALU_OP_W'(1);
    localparam logic [ALU_OP_W-1:0] ALU_SLL   = ALU_OP_W'(2);
    localparam logic [ALU_OP_W-1:0] ALU_SLT   = ALU_OP_W'(3);
    localparam logic [ALU_OP_W-1:0] ALU_SLTU  = ALU_OP_W'(4);
    localparam logic [ALU_OP_W-1:0] ALU_XOR   = ALU_OP_W'(5);
    localparam logic [ALU_OP_W-1:0] ALU_SRL   = ALU_OP_W'(6);
    localparam logic [ALU_OP_W-1:0] ALU_SRA   = ALU_OP_W'(7);
    localparam logic [ALU_OP_W-1:0] ALU_OR    = ALU_OP_W'(8);
    localparam logic [ALU_OP_W-1:0] ALU_AND   = ALU_OP_W'(9);
    localparam logic [ALU_OP_W-1:0] ALU_PASSB = ALU_OP_W'(10);

    localparam int             CW      = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam logic [CW-1:0]  TMO_MAX = CW'(MEM_TIMEOUT);

    state_t                r_state;
    state_t                w_next;
    logic [CW-1:0]         r_tmo_cnt;
    logic                  r_illegal;
    logic                  r_bus_err;
    logic                  w_legal;
    logic                  w_req;
    logic                  w_tmo_hit;
    logic [ALU_OP_W-1:0]   w_alu_fn;
    logic [1:0]            w_a;
    logic [1:0]            w_b;
    logic [ALU_OP_W-1:0]   w_op;

    always_comb begin
        w_legal = 1'b0;
        case (opcode)
            OP_R, OP_I, OP_LD, OP_ST, OP_BR,
            OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: w_legal = 1'b1;
            default:                           w_legal = 1'b0;
        endcase
    end

    // fn7_5 selects SUB only for register-register ops; SRA/SRAI for both
    always_comb begin
        w_alu_fn = ALU_ADD;
        case (fn3)
            3'b000:  w_alu_fn = (opcode == OP_R && fn7_5) ? ALU_SUB : ALU_ADD;
            3'b001:  w_alu_fn = ALU_SLL;
            3'b010:  w_alu_fn = ALU_SLT;
            3'b011:  w_alu_fn = ALU_SLTU;
            3'b100:  w_alu_fn = ALU_XOR;
            3'b101:  w_alu_fn = fn7_5 ? ALU_SRA : ALU_SRL;
            3'b110:  w_alu_fn = ALU_OR;
            default: w_alu_fn = ALU_AND;
        endcase
    end

    always_comb begin
        w_a  = 2'd0;
        w_b  = 2'd0;
        w_op = ALU_ADD;
        case (opcode)
            OP_R: begin
                w_op = w_alu_fn;
            end
            OP_I: begin
                w_b  = 2'd1;
                w_op = w_alu_fn;
            end
            OP_LD, OP_ST, OP_JALR: begin
                w_b  = 2'd1;
            end
            OP_LUI: begin
                w_a  = 2'd2;
                w_b  = 2'd1;
                w_op = ALU_PASSB;
            end
            OP_AUIPC: begin
                w_a  = 2'd1;
                w_b  = 2'd1;
            end
            default: begin
                w_op = ALU_ADD;
            end
        endcase
    end

    assign w_req     = (r_state == S_FETCH) || (r_state == S_MEM);
    assign w_tmo_hit = (MEM_TIMEOUT != 0) && w_req && !mem_ready
                       && (r_tmo_cnt == TMO_MAX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_FETCH: begin
                if (mem_ready)      w_next = S_DECODE;
                else if (w_tmo_hit) w_next = S_TRAP;
            end
            S_DECODE: begin
                w_next = w_legal ? S_EXEC : S_TRAP;
            end
            S_EXEC: begin
                case (opcode)
                    OP_LD, OP_ST: w_next = S_MEM;
                    OP_BR:        w_next = S_FETCH;
                    default:      w_next = S_WB;
                endcase
            end
            S_MEM: begin
                if (mem_ready)      w_next = (opcode == OP_ST) ? S_FETCH : S_WB;
                else if (w_tmo_hit) w_next = S_TRAP;
            end
            S_WB:    w_next = S_FETCH;
            S_TRAP:  w_next = S_TRAP;
            default: w_next = S_FETCH;
        endcase
    end

    // Wait counter restarts with every new request (state change) or completion
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tmo_cnt <= '0;
        end else if (mem_ready || (w_next != r_state)) begin
            r_tmo_cnt <= '0;
        end else if (w_req && (MEM_TIMEOUT != 0)) begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_illegal <= 1'b0;
            r_bus_err <= 1'b0;
        end else begin
            if (r_state == S_DECODE && !w_legal) r_illegal <= 1'b1;
            if (w_tmo_hit)                       r_bus_err <= 1'b1;
        end
    end

    // Reset is folded in combinationally so enables drop the instant rst rises
    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        ir_we     = 1'b0;
        pc_we     = 1'b0;
        pc_src    = 2'd0;
        alu_src_a = 2'd0;
        alu_src_b = 2'd0;
        alu_op    = ALU_ADD;
        rf_we     = 1'b0;
        wb_sel    = 2'd0;
        if (!rst) begin
            case (r_state)
                S_FETCH: begin
                    mem_req = 1'b1;
                    ir_we   = mem_ready;
                    pc_we   = mem_ready;
                end
                S_EXEC: begin
                    alu_src_a = w_a;
                    alu_src_b = w_b;
                    alu_op    = w_op;
                    case (opcode)
                        OP_BR: begin
                            pc_we  = br_taken;
                            pc_src = 2'd1;
                        end
                        OP_JAL: begin
                            pc_we  = 1'b1;
                            pc_src = 2'd1;
                        end
                        OP_JALR: begin
                            pc_we  = 1'b1;
                            pc_src = 2'd2;
                        end
                        default: pc_we = 1'b0;
                    endcase
                end
                S_MEM: begin
                    mem_req   = 1'b1;
                    mem_we    = (opcode == OP_ST);
                    alu_src_a = w_a;
                    alu_src_b = w_b;
                    alu_op    = w_op;
                end
                S_WB: begin
                    rf_we     = 1'b1;
                    alu_src_a = w_a;
                    alu_src_b = w_b;
                    alu_op    = w_op;
                    case (opcode)
                        OP_LD:          wb_sel = 2'd1;
                        OP_JAL, OP_JALR: wb_sel = 2'd2;
                        default:        wb_sel = 2'd0;
                    endcase
                end
                default: mem_req = 1'b0;
            endcase
        end
    end

    assign illegal = r_illegal;
    assign bus_err = r_bus_err;
    assign state_o = r_state;

`ifdef MULTICYCLE_PERF_EN
    logic        w_retire;
    logic [31:0] r_instret;
    logic [31:0] r_cycles;

    assign w_retire = (r_state == S_WB)
                      || (r_state == S_MEM && opcode == OP_ST && mem_ready)
                      || (r_state == S_EXEC && opcode == OP_BR);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_instret <= '0;
            r_cycles  <= '0;
        end else begin
            if (w_retire)          r_instret <= r_instret + 32'd1;
            if (r_state != S_TRAP) r_cycles  <= r_cycles + 32'd1;
        end
    end

    assign instret = r_instret;
    assign cycles  = r_cycles;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: randomized instruction stream vs per-instruction reference.
module tb_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] opcode;
    logic [2:0] fn3;
    logic       fn7_5;
    logic       br_taken;
    logic       mem_ready;
    logic       mem_req, mem_we, ir_we, pc_we, rf_we, illegal, bus_err;
    logic [1:0] pc_src, alu_src_a, alu_src_b, wb_sel;
    logic [3:0] alu_op;
    logic [2:0] state_o;

    always #5 clk = ~clk;

    multicycle_ctrl #(.MEM_TIMEOUT(15), .ALU_OP_W(4)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .fn3(fn3), .fn7_5(fn7_5),
        .br_taken(br_taken), .mem_ready(mem_ready), .mem_req(mem_req),
        .mem_we(mem_we), .ir_we(ir_we), .pc_we(pc_we), .pc_src(pc_src),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .rf_we(rf_we), .wb_sel(wb_sel), .illegal(illegal),
        .bus_err(bus_err), .state_o(state_o)
    );

    typedef struct {
        int cycles;
        bit chk_alu;
        int alu;
        bit chk_pc;
        int pc;
        int wb;
        bit has_mem;
        int mem_we_cyc;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk  = 0;
    int   n_pass = 0;
    bit   mon_en = 1'b0;
    int   opc_t[9] = '{32'h33, 32'h13, 32'h03, 32'h23, 32'h63,
                       32'h6F, 32'h67, 32'h37, 32'h17};

    int o_cycles, o_alu, o_pc, o_rf_cnt, o_wb_sel, o_mw_cnt;
    int o_mem_bad, o_ir_cnt, o_fpc_ok, o_flags;

    task automatic chk(input string nm, input int act, input int req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0d, required %0d", nm, act, req);
    endtask

    function automatic int outs();
        return int'({mem_req, mem_we, ir_we, pc_we, pc_src, alu_src_a,
                     alu_src_b, alu_op, rf_we, wb_sel, illegal, bus_err,
                     state_o});
    endfunction

    function automatic int alu_pack(input int a, input int b, input int op);
        return a * 256 + b * 16 + op;
    endfunction

    // Instruction-level reference: class 0..8 = R,I,LD,ST,BR,JAL,JALR,LUI,AUIPC
    function automatic int ref_op(input int cls, input int f3, input int f7);
        int tbl[8];
        tbl = '{0, 2, 3, 4, 5, 6, 8, 9};
        if (cls == 0 && f3 == 0 && f7 == 1) return 1;
        if (f3 == 5 && f7 == 1) return 7;
        return tbl[f3];
    endfunction

    task automatic run_instr(input int cls, input int f3, input int f7,
                             input int br, input int fw, input int mw);
        exp_t e;
        bit   seq[$];
        bit   wb;
        bit   mem;
        int   wsel;
        mem  = (cls == 2 || cls == 3);
        wb   = !(cls == 3 || cls == 4);
        wsel = (cls == 2) ? 1 : ((cls == 5 || cls == 6) ? 2 : 0);
        for (int i = 0; i < fw; i++) seq.push_back(1'b0);
        seq.push_back(1'b1);
        seq.push_back(1'($urandom_range(0, 1)));
        seq.push_back(1'($urandom_range(0, 1)));
        if (mem) begin
            for (int i = 0; i < mw; i++) seq.push_back(1'b0);
            seq.push_back(1'b1);
        end
        if (wb) seq.push_back(1'($urandom_range(0, 1)));
        e.cycles  = seq.size();
        e.chk_alu = !(cls == 4 || cls == 5);
        case (cls)
            0:       e.alu = alu_pack(0, 0, ref_op(cls, f3, f7));
            1:       e.alu = alu_pack(0, 1, ref_op(cls, f3, f7));
            7:       e.alu = alu_pack(2, 1, 10);
            8:       e.alu = alu_pack(1, 1, 0);
            default: e.alu = alu_pack(0, 1, 0);
        endcase
        e.chk_pc = (cls >= 4 && cls <= 6);
        case (cls)
            4:       e.pc = br * 4 + 1;
            5:       e.pc = 4 + 1;
            6:       e.pc = 4 + 2;
            default: e.pc = 0;
        endcase
        e.wb         = wb ? 4 + wsel : 0;
        e.has_mem    = mem;
        e.mem_we_cyc = (cls == 3) ? mw + 1 : 0;
        exp_q.push_back(e);
        opcode   = 7'(opc_t[cls]);
        fn3      = 3'(f3);
        fn7_5    = 1'(f7);
        br_taken = 1'(br);
        foreach (seq[i]) begin
            mem_ready = seq[i];
            @(posedge clk);
            #1;
        end
    endtask

    task automatic close_instr();
        exp_t e;
        if (exp_q.size() == 0) begin
            chk("extra_instr", 1, 0);
            return;
        end
        e = exp_q.pop_front();
        chk("cycles", o_cycles, e.cycles);
        if (e.chk_alu) chk("exec_alu", o_alu, e.alu);
        chk("exec_pc", e.chk_pc ? o_pc : (o_pc & 4), e.pc);
        chk("wb", o_rf_cnt * 4 + o_wb_sel, e.wb);
        chk("mem_we_cycles", o_mw_cnt, e.mem_we_cyc);
        if (e.has_mem) chk("mem_alu_hold", o_mem_bad, 0);
        chk("fetch_ir_pc", o_ir_cnt * 2 + o_fpc_ok, 3);
        chk("trap_flags", o_flags, 0);
    endtask

    initial begin
        int prev;
        bit started;
        prev    = 7;
        started = 1'b0;
        forever begin
            @(negedge clk);
            if (!mon_en) begin
                prev    = 7;
                started = 1'b0;
            end else begin
                if (state_o == 3'd0 && prev != 0) begin
                    if (started) close_instr();
                    started   = 1'b1;
                    o_cycles  = 0; o_alu = -1; o_pc = 0; o_rf_cnt = 0;
                    o_wb_sel  = 0; o_mw_cnt = 0; o_mem_bad = 0;
                    o_ir_cnt  = 0; o_fpc_ok = 0; o_flags = 0;
                end
                o_cycles++;
                if (ir_we) begin
                    o_ir_cnt++;
                    o_fpc_ok = (pc_we && pc_src == 2'd0) ? 1 : 0;
                end
                if (state_o == 3'd2) begin
                    o_alu = alu_pack(alu_src_a, alu_src_b, alu_op);
                    o_pc  = pc_we * 4 + pc_src;
                end
                if (state_o == 3'd3) begin
                    if (mem_we) o_mw_cnt++;
                    if (alu_pack(alu_src_a, alu_src_b, alu_op) != o_alu)
                        o_mem_bad++;
                end
                if (rf_we) begin
                    o_rf_cnt++;
                    o_wb_sel = wb_sel;
                end
                o_flags |= {illegal, bus_err};
                prev = state_o;
            end
        end
    end

    task automatic do_reset();
        rst       = 1'b1;
        mem_ready = 1'b1;
        br_taken  = 1'b1;
        opcode    = 7'h33;
        fn3       = 3'd0;
        fn7_5     = 1'b0;
        @(posedge clk);
        #1;
        chk("reset_outputs", outs(), 0);
        rst = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset();
        mon_en = 1'b1;
        run_instr(0, 0, 0, 0, 0, 0);
        run_instr(0, 0, 1, 0, 0, 0);
        run_instr(1, 0, 1, 0, 0, 0);
        run_instr(1, 5, 1, 0, 0, 0);
        run_instr(2, 2, 0, 0, 0, 2);
        run_instr(3, 2, 0, 0, 1, 0);
        run_instr(4, 0, 0, 0, 0, 0);
        run_instr(4, 0, 0, 1, 0, 0);
        run_instr(5, 0, 0, 0, 0, 0);
        run_instr(6, 0, 0, 0, 0, 0);
        for (int n = 0; n < 40; n++) begin
            int cls, fw, mw;
            cls = $urandom_range(0, 8);
            fw  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 14) : 0;
            mw  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 14) : 0;
            run_instr(cls, $urandom_range(0, 7), $urandom_range(0, 1),
                      $urandom_range(0, 1), fw, mw);
        end
        mem_ready = 1'b0;
        @(negedge clk);
        #1;
        mon_en = 1'b0;
        chk("queue_drained", exp_q.size(), 0);

        do_reset();
        opcode = 7'h7F;
        @(posedge clk); #1;
        chk("illegal_decode", outs(), 1);
        @(posedge clk); #1;
        chk("illegal_trap", outs(), 21);
        for (int i = 0; i < 10; i++) begin
            mem_ready = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            chk("illegal_hold", outs(), 21);
        end
        rst = 1'b1;
        #1;
        chk("illegal_cleared", outs(), 0);

        do_reset();
        opcode = 7'h00;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("illegal_zero_op", outs(), 21);

        do_reset();
        mem_ready = 1'b0;
        repeat (15) @(posedge clk);
        #1;
        chk("fetch_tmo_wait", outs(), 1 << 21);
        @(posedge clk); #1;
        chk("fetch_tmo_trap", outs(), 13);

        do_reset();
        mem_ready = 1'b0;
        repeat (15) @(posedge clk);
        #1;
        mem_ready = 1'b1;
        #1;
        chk("limit_ready_wins", {ir_we, pc_we}, 3);
        @(posedge clk); #1;
        chk("limit_no_trap", outs(), 1);

        do_reset();
        mem_ready = 1'b0;
        #1;
        chk("fetch_req", mem_req, 1);
        rst = 1'b1;
        #1;
        chk("async_reset_drop", outs(), 0);

        do_reset();
        opcode = 7'h03;
        @(posedge clk); #1;
        mem_ready = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        repeat (15) @(posedge clk);
        #1;
        chk("mem_tmo_wait", state_o, 3);
        @(posedge clk); #1;
        chk("mem_tmo_trap", outs(), 13);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
